bank_axi3_rd_responder: RTL

AXI3 read-channel responder that models the memory side of the bank BIU's read port. It accepts AR requests into a small in-order queue and waits a fixed latency per request. It then returns `arlen+1` R beats whose data is a deterministic function of the beat address, honouring `rready` backpressure and flagging illegal or out-of-range requests. The block sits opposite the BIU's `biu_axi3_ar*`/`biu_axi3_r*` ports in bank-level simulation and FPGA bring-up.

---
 rtl/bank_axi3_pkg.sv | 28 ++
 rtl/bank_sync_fifo.sv | 53 +++++
 rtl/bank_axi3_rd_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bank_axi3_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | bank_axi3_pkg                                                    |
// | Shared AXI3 burst/response encodings and read-responder states.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bank_axi3_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/bank_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | bank_sync_fifo                                                   |
// | Single-clock FIFO with full/empty flags and show-ahead head data.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bank_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/bank_axi3_rd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | bank_axi3_rd_responder                                           |
// | AXI3 read-side memory model: queued AR, fixed latency, R bursts  |
// | carrying address-derived data with DECERR/SLVERR classification. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bank_axi3_rd_responder
  import bank_axi3_pkg::*;
#(
  parameter int                    ID_WIDTH   = 6,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 256,
  parameter int                    AR_DEPTH   = 4,
  parameter int                    RD_LATENCY = 3,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = ADDR_WIDTH'(32'h1000_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  biu_axi3_arvalid_i,
  output logic                  biu_axi3_arready_o,
  input  logic [ID_WIDTH-1:0]   biu_axi3_arid_i,
  input  logic [ADDR_WIDTH-1:0] biu_axi3_araddr_i,
  input  logic [2:0]            biu_axi3_arsize_i,
  input  logic [3:0]            biu_axi3_arlen_i,
  input  logic [1:0]            biu_axi3_arburst_i,
  output logic                  biu_axi3_rvalid_o,
  input  logic                  biu_axi3_rready_i,
  output logic [ID_WIDTH-1:0]   biu_axi3_rid_o,
  output logic [DATA_WIDTH-1:0] biu_axi3_rdata_o,
  output logic [1:0]            biu_axi3_rresp_o,
  output logic                  biu_axi3_rlast_o
);

  localparam int         NREP     = DATA_WIDTH / 32;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam int         LAT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int         AR_W     = ID_WIDTH + ADDR_WIDTH + 3 + 4 + 2;

  // AR queue
  logic                  r_ar_en;
  logic                  w_ar_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [AR_W-1:0]       w_ar_wdata;
  logic [AR_W-1:0]       w_ar_rdata;
  logic [ID_WIDTH-1:0]   w_q_id;
  logic [ADDR_WIDTH-1:0] w_q_addr;
  logic [2:0]            w_q_size;
  logic [3:0]            w_q_len;
  logic [1:0]            w_q_burst;

  // arready stays low until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ar_en <= 1'b0;
    else         r_ar_en <= 1'b1;
  end

  assign biu_axi3_arready_o = r_ar_en && !w_fifo_full;
  assign w_ar_push          = biu_axi3_arvalid_i && biu_axi3_arready_o;
  assign w_ar_wdata         = {biu_axi3_arid_i, biu_axi3_araddr_i, biu_axi3_arsize_i,
                               biu_axi3_arlen_i, biu_axi3_arburst_i};
  assign {w_q_id, w_q_addr, w_q_size, w_q_len, w_q_burst} = w_ar_rdata;

  bank_sync_fifo #(
    .WIDTH (AR_W),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_ar_push),
    .i_data  (w_ar_wdata),
    .i_pop   (w_pop),
    .o_data  (w_ar_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Classification of the queue head, captured when it is popped
  logic [ADDR_WIDTH-1:0] w_q_bytes;
  logic [ADDR_WIDTH-1:0] w_q_off;
  logic                  w_q_wrap_len_ok;
  logic                  w_q_slverr;
  logic [1:0]            w_q_resp;

  assign w_q_bytes       = ADDR_WIDTH'(1) << w_q_size;
  // Offset compare also rejects addresses below MEM_BASE via wraparound.
  assign w_q_off         = w_q_addr - MEM_BASE;
  assign w_q_wrap_len_ok = (w_q_len == 4'd1) || (w_q_len == 4'd3) ||
                           (w_q_len == 4'd7) || (w_q_len == 4'd15);
  assign w_q_slverr      = (w_q_burst == BURST_RSVD) || (w_q_size > MAX_SIZE) ||
                           ((w_q_burst == BURST_WRAP) && !w_q_wrap_len_ok) ||
                           ((w_q_burst == BURST_WRAP) &&
                            (|(w_q_addr & (w_q_bytes - ADDR_WIDTH'(1)))));
  assign w_q_resp        = (w_q_off >= MEM_SIZE) ? RESP_DECERR :
                           w_q_slverr            ? RESP_SLVERR : RESP_OKAY;

  // Current request
  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [3:0]            r_len;
  logic [1:0]            r_burst;
  logic [1:0]            r_resp;
  logic [3:0]            r_beat_cnt;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  w_in_burst;
  logic                  w_r_hs;
  logic                  w_last;

  assign w_in_burst = (r_state == ST_BURST);
  assign w_r_hs     = w_in_burst && biu_axi3_rready_i;
  assign w_last     = (r_beat_cnt == r_len);

  // Beat address generator
  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_bytes     = ADDR_WIDTH'(1) << r_size;
  assign w_incr      = (r_addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;
  assign w_wrap_mask = (w_bytes * (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);

  always_comb begin
    w_addr_nxt = w_incr;
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:     w_addr_nxt = w_incr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (RD_LATENCY == 0) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (w_r_hs && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_len      <= '0;
      r_burst    <= '0;
      r_resp     <= RESP_OKAY;
      r_beat_cnt <= '0;
      r_lat_cnt  <= '0;
    end else if (w_pop) begin
      r_id       <= w_q_id;
      r_addr     <= w_q_addr;
      r_size     <= w_q_size;
      r_len      <= w_q_len;
      r_burst    <= w_q_burst;
      r_resp     <= w_q_resp;
      r_beat_cnt <= '0;
      r_lat_cnt  <= LAT_W'(RD_LATENCY);
    end else if (r_state == ST_WAIT) begin
      r_lat_cnt  <= r_lat_cnt - 1'b1;
    end else if (w_r_hs && !w_last) begin
      r_addr     <= w_addr_nxt;
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  // R payload comes straight from registers, so it holds under backpressure
  logic [31:0] w_addr32;
  logic        w_data_en;

  assign w_addr32  = 32'(r_addr);
  assign w_data_en = w_in_burst && (r_resp == RESP_OKAY);

  assign biu_axi3_rvalid_o = w_in_burst;
  assign biu_axi3_rid_o    = w_in_burst ? r_id : '0;
  assign biu_axi3_rresp_o  = w_in_burst ? r_resp : RESP_OKAY;
  assign biu_axi3_rlast_o  = w_in_burst && w_last;

  generate
    for (genvar g = 0; g < NREP; g++) begin : g_rdata
      assign biu_axi3_rdata_o[g*32 +: 32] = w_data_en ? w_addr32 : 32'h0;
    end
  endgenerate

endmodule
`default_nettype wire
